// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling, optional parity; rx_valid 1 cycle after stop sample.
// Backpressure: a held frame waits for rx_ready; a frame completing while one is still held is dropped with rx_overrun.
module uart_rx #(
  parameter int BAUD_DIV   = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  output logic                 rx_busy
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
  localparam logic          POLARITY  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP, BRK_WAIT
  } state_t;

  state_t               state;
  logic                 rx_q, rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bitcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, done;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_q          <= 1'b1;
      rx_s          <= 1'b1;
      state         <= IDLE;
      cnt           <= '0;
      bitcnt        <= '0;
      shreg         <= '0;
      perr          <= 1'b0;
      ferr          <= 1'b0;
      done          <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
      rx_busy       <= 1'b0;
    end else begin
      rx_q       <= rx;
      rx_s       <= rx_q;
      done       <= 1'b0;
      rx_overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt     <= HALF_LOAD;
            state   <= START;
            rx_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end else begin
            cnt    <= FULL_LOAD;
            bitcnt <= '0;
            perr   <= 1'b0;
            state  <= DATA;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
            bitcnt <= bitcnt + 1'b1;
            cnt    <= FULL_LOAD;
            if (bitcnt == LAST_BIT)
              state <= (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            perr  <= ^shreg ^ rx_s ^ POLARITY;
            cnt   <= FULL_LOAD;
            state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ferr <= ~rx_s;
            done <= 1'b1;
            if (rx_s) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= BRK_WAIT;
            end
          end
        end
        BRK_WAIT: begin
          // a line held low after a bad stop bit must not look like a new start bit
          if (rx_s) begin
            state   <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase

      // completion and handshake may coincide: the new frame replaces the accepted one
      if (done) begin
        if (!rx_valid || rx_ready) begin
          rx_data       <= shreg;
          rx_parity_err <= perr;
          rx_frame_err  <= ferr;
          rx_valid      <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end else if (rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: one 8N1 instance and one even-parity instance driven by a serial line model.
module tb_uart_rx;

  localparam int BD = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] d_a, d_b;
  logic       v_a, v_b, pe_a, pe_b, fe_a, fe_b, ov_a, ov_b, bz_a, bz_b;

  uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(d_a), .rx_valid(v_a), .rx_ready(rdy_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a), .rx_overrun(ov_a), .rx_busy(bz_a));

  uart_rx #(.BAUD_DIV(BD), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(d_b), .rx_valid(v_b), .rx_ready(rdy_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b), .rx_overrun(ov_b), .rx_busy(bz_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  frm_t got_a[$], got_b[$], exp_q[$];
  int   ov_cnt_a = 0, vhi_a = 0, rise_cyc_a = 0;
  logic v_a_d = 1'b0;

  // accepted frames are collected on the opposite edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (v_a && rdy_a) got_a.push_back({d_a, pe_a, fe_a});
      if (v_b && rdy_b) got_b.push_back({d_b, pe_b, fe_b});
      if (ov_a) ov_cnt_a++;
      if (v_a) vhi_a++;
      if (v_a && !v_a_d) rise_cyc_a = cyc;
    end
    v_a_d = v_a;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic frm_t model(input logic [7:0] d, input bit par_en, input bit odd,
                                 input int pbit, input bit stop_ok);
    frm_t f;
    int   ones;
    ones = $countones(d) + ((pbit > 0) ? 1 : 0);
    f.d  = d;
    f.pe = par_en && ((ones % 2) != (odd ? 1 : 0));
    f.fe = !stop_ok;
    return f;
  endfunction

  task automatic line(input int sel, input logic v);
    if (sel == 0) rx_a = v; else rx_b = v;
  endtask

  task automatic bit_time(input int sel, input logic v);
    line(sel, v);
    repeat (BD) @(negedge clk);
  endtask

  // pbit < 0: no parity bit. stop_low > 0: stop held low that many bit times, line left low.
  task automatic send(input int sel, input logic [7:0] d, input int pbit, input int stop_low);
    bit_time(sel, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(sel, d[i]);
    if (pbit >= 0) bit_time(sel, pbit[0]);
    if (stop_low > 0) begin
      line(sel, 1'b0);
      repeat (stop_low * BD) @(negedge clk);
    end else begin
      bit_time(sel, 1'b1);
    end
  endtask

  task automatic wait_frames(input int sel, input int n, input int budget);
    int k = 0;
    while ((((sel == 0) ? got_a.size() : got_b.size()) < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  frm_t       f, e;
  int         t0, lat, vh0, ov0, fall;
  bit         saw;
  logic [7:0] b;
  int         pb;

  initial begin
    rst_n = 1'b0; rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid_a", 32'(v_a), 0);
    chk("rst_data_a", 32'(d_a), 0);
    chk("rst_busy_a", 32'(bz_a), 0);
    chk("rst_flags_a", 32'({pe_a, fe_a, ov_a}), 0);
    chk("rst_valid_b", 32'({v_b, bz_b, pe_b, fe_b, ov_b}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 0xA5 8N1: latency and single-cycle valid with ready tied high
    vh0 = vhi_a;
    t0  = cyc;
    send(0, 8'hA5, -1, 0);
    wait_frames(0, 1, 200);
    chk("a5_count", 32'(got_a.size()), 1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk("a5_frame", {22'b0, f}, {22'b0, model(8'hA5, 0, 0, -1, 1)});
    end
    lat = rise_cyc_a - t0;
    n_chk++;
    assert (lat >= 154 && lat <= 156) else begin
      n_fail++;
      $error("FAIL a5_latency observed=%0d expected=155+-1", lat);
    end
    repeat (5) @(negedge clk);
    chk("a5_pulse_width", 32'(vhi_a - vh0), 1);

    // glitch shorter than half a bit
    vh0 = vhi_a; saw = 0; fall = -1;
    t0 = cyc;
    line(0, 1'b0);
    repeat (4) @(negedge clk);
    line(0, 1'b1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bz_a) saw = 1;
      else if (saw && fall < 0) fall = cyc - t0;
    end
    chk("glitch_busy_seen", 32'(saw), 1);
    n_chk++;
    assert (fall >= 9 && fall <= 13) else begin
      n_fail++;
      $error("FAIL glitch_busy_fall observed=%0d expected=9..13", fall);
    end
    chk("glitch_no_valid", 32'(vhi_a - vh0), 0);

    // random back-to-back 8N1 frames
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_q.push_back(model(b, 0, 0, -1, 1));
      send(0, b, -1, 0);
    end
    wait_frames(0, 6, 300);
    chk("rnd_a_count", 32'(got_a.size()), 6);
    for (int i = 0; i < 6 && got_a.size() > 0; i++) begin
      f = got_a.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("rnd_a_%0d", i), {22'b0, f}, {22'b0, e});
    end
    exp_q.delete();

    // even parity: correct and wrong parity bit on 0x03
    send(1, 8'h03, 0, 0);
    send(1, 8'h03, 1, 0);
    wait_frames(1, 2, 300);
    chk("par_count", 32'(got_b.size()), 2);
    if (got_b.size() == 2) begin
      f = got_b.pop_front();
      chk("par_ok_frame", {22'b0, f}, {22'b0, model(8'h03, 1, 0, 0, 1)});
      f = got_b.pop_front();
      chk("par_bad_pe", 32'(f.pe), 1);
      chk("par_bad_data", 32'(f.d), 32'h03);
    end

    for (int i = 0; i < 6; i++) begin
      b  = 8'($urandom);
      pb = int'($urandom_range(0, 1));
      exp_q.push_back(model(b, 1, 0, pb, 1));
      send(1, b, pb, 0);
    end
    wait_frames(1, 6, 300);
    chk("rnd_b_count", 32'(got_b.size()), 6);
    for (int i = 0; i < 6 && got_b.size() > 0; i++) begin
      f = got_b.pop_front();
      e = exp_q.pop_front();
      chk($sformatf("rnd_b_%0d", i), {22'b0, f}, {22'b0, e});
    end
    exp_q.delete();

    // stop bit held low for three bit times
    vh0 = vhi_a;
    send(0, 8'h7E, -1, 3);
    chk("brk_count", 32'(got_a.size()), 1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk("brk_frame", {22'b0, f}, {22'b0, model(8'h7E, 0, 0, -1, 0)});
    end
    chk("brk_busy_low_line", 32'(bz_a), 1);
    line(0, 1'b1);
    repeat (2 * BD) @(negedge clk);
    chk("brk_busy_after", 32'(bz_a), 0);
    chk("brk_single_frame", 32'(vhi_a - vh0), 1);
    send(0, 8'h11, -1, 0);
    wait_frames(0, 1, 200);
    chk("brk_next_count", 32'(got_a.size()), 1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk("brk_next_frame", {22'b0, f}, {22'b0, model(8'h11, 0, 0, -1, 1)});
    end

    // overrun: consumer stalled across two back-to-back frames
    rdy_a = 1'b0;
    ov0 = ov_cnt_a;
    send(0, 8'h12, -1, 0);
    send(0, 8'h34, -1, 0);
    repeat (20) @(negedge clk);
    chk("ovr_valid_held", 32'(v_a), 1);
    chk("ovr_data_held", 32'(d_a), 32'h12);
    chk("ovr_flags_held", 32'({pe_a, fe_a}), 0);
    chk("ovr_pulses", 32'(ov_cnt_a - ov0), 1);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("ovr_valid_cleared", 32'(v_a), 0);
    chk("ovr_accepted_count", 32'(got_a.size()), 1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk("ovr_accepted_frame", {22'b0, f}, {22'b0, model(8'h12, 0, 0, -1, 1)});
    end

    // reset midway through 0x5A's data bits
    b = 8'h5A;
    vh0 = vhi_a;
    bit_time(0, 1'b0);
    for (int i = 0; i < 4; i++) bit_time(0, b[i]);
    chk("mid_busy_before_rst", 32'(bz_a), 1);
    rst_n = 1'b0;
    line(0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(bz_a), 0);
    chk("mid_rst_valid", 32'(v_a), 0);
    chk("mid_rst_data", 32'(d_a), 0);
    repeat (20 * BD) @(negedge clk);
    chk("mid_no_frame", 32'(vhi_a - vh0), 0);
    send(0, 8'hC3, -1, 0);
    wait_frames(0, 1, 200);
    chk("mid_next_count", 32'(got_a.size()), 1);
    if (got_a.size() > 0) begin
      f = got_a.pop_front();
      chk("mid_next_frame", {22'b0, f}, {22'b0, model(8'hC3, 0, 0, -1, 1)});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
